fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 32-entry x 32-bit program memory, which has a combinational read. It owns the program counter, drives the memory address, and registers the returned word into an instruction register. It issues instructions to the execute stage over a valid/ready handshake and handles jumps, external redirects and halt. Throughput is one instruction per cycle when the execute stage is ready.

---
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, instruction register, issue handshake, jump/redirect/halt
module fetch_sequencer #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [4:0]  JMP_OP  = 5'b11000,
  parameter logic [4:0]  HALT_OP = 5'b11111,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted,
  output logic              busy,
  output logic              pc_wrapped,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic                r_ir_valid;
  logic                r_halted;
  logic                r_busy;
  logic                r_wrapped;
  logic [CNT_W-1:0]    r_count;

  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_pc_at_max;
  logic                w_accept;
  logic [4:0]          w_opcode;

  assign w_pc_inc    = r_pc + 1'b1;
  assign w_pc_at_max = (r_pc == {ADDR_W{1'b1}});
  assign w_accept    = r_ir_valid & ir_ready;
  assign w_opcode    = r_ir[DATA_W-1 -: 5];

  // Fetch/issue state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_busy     <= 1'b0;
      r_wrapped  <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          r_ir_valid <= 1'b0;
          if (start) begin
            r_pc      <= '0;
            r_wrapped <= 1'b0;
            r_count   <= '0;
            r_halted  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (br_valid) begin
            r_pc       <= br_target;
            r_ir_valid <= 1'b0;
          end else begin
            r_ir       <= instr_in;
            r_pc       <= w_pc_inc;
            r_ir_valid <= 1'b1;
            r_state    <= S_ISSUE;
            if (w_pc_at_max) r_wrapped <= 1'b1;
          end
        end
        S_ISSUE: begin
          // An instruction accepted alongside a redirect still retires.
          if (w_accept) r_count <= r_count + 1'b1;
          if (br_valid) begin
            r_pc       <= br_target;
            r_ir_valid <= 1'b0;
            r_state    <= S_FETCH;
          end else if (w_accept) begin
            if (w_opcode == JMP_OP) begin
              r_pc       <= r_ir[ADDR_W-1:0];
              r_ir_valid <= 1'b0;
              r_state    <= S_FETCH;
            end else if (w_opcode == HALT_OP) begin
              r_ir_valid <= 1'b0;
              r_halted   <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_HALT;
            end else begin
              r_ir    <= instr_in;
              r_pc    <= w_pc_inc;
              if (w_pc_at_max) r_wrapped <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ir_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign pc_addr     = r_pc;
  assign ir_out      = r_ir;
  assign ir_valid    = r_ir_valid;
  assign halted      = r_halted;
  assign busy        = r_busy;
  assign pc_wrapped  = r_wrapped;
  assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  pc_addr;
  logic [31:0] instr_in;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_valid;
  logic [4:0]  br_target;
  logic        halted;
  logic        busy;
  logic        pc_wrapped;
  logic [15:0] instr_count;

  logic [31:0] mem [32];
  int          total;
  int          bad;

  fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc_addr     (pc_addr),
    .instr_in    (instr_in),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .halted      (halted),
    .busy        (busy),
    .pc_wrapped  (pc_wrapped),
    .instr_count (instr_count)
  );

  assign instr_in = mem[pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h80400001;
    mem[1] = 32'h80800002;
    mem[2] = 32'h80C00003;
    mem[3] = 32'h81000004;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    fill_mem();
    #12;
    check("rst_valid",  {31'b0, ir_valid}, 32'd0);
    check("rst_ir",     ir_out, 32'd0);
    check("rst_pc",     {27'b0, pc_addr}, 32'd0);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_cnt",    {16'b0, instr_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back issue with ready held high
    ir_ready = 1'b1;
    do_start();
    check("a_fetch_valid", {31'b0, ir_valid}, 32'd0);
    check("a_fetch_busy",  {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("a_valid", {31'b0, ir_valid}, 32'd1);
      check("a_ir", ir_out, mem[i]);
    end
    step();
    check("a_cnt4", {16'b0, instr_count}, 32'd4);

    // Stall with ready low
    do_reset();
    ir_ready = 1'b0;
    do_start();
    step();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("b_ir",  ir_out, 32'h80800002);
      check("b_pc",  {27'b0, pc_addr}, 32'd2);
      check("b_cnt", {16'b0, instr_count}, 32'd1);
    end
    ir_ready = 1'b1;
    step();
    check("b_resume_ir",  ir_out, 32'h80C00003);
    check("b_resume_cnt", {16'b0, instr_count}, 32'd2);

    // Jump costs one bubble
    do_reset();
    mem[4] = 32'hC0000009;
    mem[9] = 32'h82400009;
    ir_ready = 1'b1;
    do_start();
    for (int i = 0; i < 5; i++) step();
    check("c_jmp_ir", ir_out, 32'hC0000009);
    step();
    check("c_bubble", {31'b0, ir_valid}, 32'd0);
    check("c_pc9",    {27'b0, pc_addr}, 32'd9);
    step();
    check("c_tgt_valid", {31'b0, ir_valid}, 32'd1);
    check("c_tgt_ir",    ir_out, 32'h82400009);

    // Redirect drops a pending word, then redirect with accept
    do_reset();
    fill_mem();
    mem[20] = 32'h85000014;
    ir_ready = 1'b0;
    do_start();
    step();
    br_valid = 1'b1; br_target = 5'd20;
    step();
    br_valid = 1'b0;
    check("d_drop_valid", {31'b0, ir_valid}, 32'd0);
    check("d_drop_cnt",   {16'b0, instr_count}, 32'd0);
    check("d_drop_pc",    {27'b0, pc_addr}, 32'd20);
    step();
    check("d_tgt_ir",    ir_out, 32'h85000014);
    check("d_tgt_valid", {31'b0, ir_valid}, 32'd1);
    ir_ready = 1'b1; br_valid = 1'b1; br_target = 5'd20;
    step();
    br_valid = 1'b0;
    check("d_acc_cnt",   {16'b0, instr_count}, 32'd1);
    check("d_acc_valid", {31'b0, ir_valid}, 32'd0);
    step();
    check("d_acc_ir", ir_out, 32'h85000014);

    // Halt, redirect ignored in HALT, restart
    do_reset();
    fill_mem();
    mem[6] = 32'hF8000000;
    ir_ready = 1'b1;
    do_start();
    for (int i = 0; i < 8; i++) step();
    check("e_halted", {31'b0, halted}, 32'd1);
    check("e_valid",  {31'b0, ir_valid}, 32'd0);
    check("e_cnt",    {16'b0, instr_count}, 32'd7);
    check("e_pc",     {27'b0, pc_addr}, 32'd7);
    check("e_busy",   {31'b0, busy}, 32'd0);
    br_valid = 1'b1; br_target = 5'd3;
    step();
    br_valid = 1'b0;
    check("e_br_ign_pc",  {27'b0, pc_addr}, 32'd7);
    check("e_br_ign_hlt", {31'b0, halted}, 32'd1);
    do_start();
    check("e_rs_pc",   {27'b0, pc_addr}, 32'd0);
    check("e_rs_cnt",  {16'b0, instr_count}, 32'd0);
    check("e_rs_hlt",  {31'b0, halted}, 32'd0);
    check("e_rs_busy", {31'b0, busy}, 32'd1);
    step();
    check("e_rs_ir", ir_out, 32'h80400001);

    // PC wrap and asynchronous reset mid-ISSUE
    do_reset();
    fill_mem();
    ir_ready = 1'b1;
    do_start();
    for (int i = 0; i < 31; i++) step();
    check("f_pc31",   {27'b0, pc_addr}, 32'd31);
    check("f_nowrap", {31'b0, pc_wrapped}, 32'd0);
    step();
    check("f_pc0",  {27'b0, pc_addr}, 32'd0);
    check("f_wrap", {31'b0, pc_wrapped}, 32'd1);
    check("f_ir31", ir_out, mem[31]);
    ir_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("f_ar_valid", {31'b0, ir_valid}, 32'd0);
    check("f_ar_ir",    ir_out, 32'd0);
    check("f_ar_cnt",   {16'b0, instr_count}, 32'd0);
    check("f_ar_wrap",  {31'b0, pc_wrapped}, 32'd0);
    check("f_ar_busy",  {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
